sram_burst_ctrl: RTL and testbench

SRAM_BURST_CTRL -- requirements
Module: sram_burst_ctrl

---
 rtl/sram_burst_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_sram_burst_ctrl.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_burst_ctrl.sv
// ---------------------------------------------------------------------------
// sram_burst_ctrl
//
// Turns burst commands (start address + length) into single-beat accesses on
// a synchronous SRAM with one cycle of read latency.
//
//   Command port : i_cmd_valid / o_cmd_ready, i_cmd_wr, i_cmd_addr, i_cmd_len
//                  (length is beats minus one).
//   Write beats  : i_wdata_valid / o_wdata_ready, i_wdata.
//   Read beats   : o_rdata_valid / i_rdata_ready, o_rdata (2-entry buffer).
//   SRAM side    : o_sram_addr, o_sram_data, o_sram_wen, o_sram_oen (all
//                  registered), i_sram_data (valid one cycle after oen).
//   Status       : o_busy (not idle), o_done (one pulse per finished burst).
//   i_clk rising-edge clock, i_rst asynchronous active-high reset.
//
// Also contains sram_burst_ctrl_chk, a property checker bound in by the top.
// ---------------------------------------------------------------------------

// Property checker: SRAM enables are exclusive and the read buffer never
// holds more beats than it has room for.
module sram_burst_ctrl_chk (
  input logic       clk,
  input logic       rst,
  input logic       sram_wen,
  input logic       sram_oen,
  input logic [2:0] read_in_use
);

  a_wen_oen_exclusive : assert property (@(posedge clk) disable iff (rst)
    !(sram_wen && sram_oen));

  a_read_room : assert property (@(posedge clk) disable iff (rst)
    read_in_use <= 3'd2);

endmodule

module sram_burst_ctrl #(
  parameter int BW_DATA = 256,
  parameter int BW_ADDR = 10
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic               i_cmd_wr,
  input  logic [BW_ADDR-1:0] i_cmd_addr,
  input  logic [BW_ADDR-1:0] i_cmd_len,
  input  logic               i_wdata_valid,
  output logic               o_wdata_ready,
  input  logic [BW_DATA-1:0] i_wdata,
  output logic               o_rdata_valid,
  input  logic               i_rdata_ready,
  output logic [BW_DATA-1:0] o_rdata,
  output logic [BW_ADDR-1:0] o_sram_addr,
  output logic [BW_DATA-1:0] o_sram_data,
  output logic               o_sram_wen,
  output logic               o_sram_oen,
  input  logic [BW_DATA-1:0] i_sram_data,
  output logic               o_busy,
  output logic               o_done
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [BW_ADDR-1:0] ADDR_ONE = BW_ADDR'(1);

  state_t             state_r;
  state_t             state_nxt_s;

  logic [BW_ADDR-1:0] cur_addr_r;
  logic [BW_ADDR-1:0] beat_cnt_r;

  logic [BW_ADDR-1:0] sram_addr_r;
  logic [BW_DATA-1:0] sram_data_r;
  logic               sram_wen_r;
  logic               sram_oen_r;
  logic               cap_pend_r;   // SRAM data for last cycle's oen is on i_sram_data now
  logic               done_r;

  logic [BW_DATA-1:0] fifo_mem_r [2];
  logic               fifo_wr_ptr_r;
  logic               fifo_rd_ptr_r;
  logic [1:0]         fifo_cnt_r;

  logic               cmd_ready_s;
  logic               cmd_hs_s;
  logic               wdata_ready_s;
  logic               wr_hs_s;
  logic               last_beat_s;
  logic [2:0]         read_in_use_s;
  logic               rd_issue_s;
  logic               beat_issue_s;
  logic               rdata_valid_s;
  logic               fifo_push_s;
  logic               fifo_pop_s;
  logic               drain_last_s;

  // Handshake and issue decisions derived from the current state.
  always_comb begin
    cmd_ready_s   = 1'b0;
    cmd_hs_s      = 1'b0;
    wdata_ready_s = 1'b0;
    wr_hs_s       = 1'b0;
    rd_issue_s    = 1'b0;
    drain_last_s  = 1'b0;

    // Ready is gated by reset so nothing is accepted while reset is held.
    if (state_r == ST_IDLE) begin
      cmd_ready_s = ~i_rst;
    end else begin
      cmd_ready_s = 1'b0;
    end
    cmd_hs_s = i_cmd_valid & cmd_ready_s;

    if (state_r == ST_WRITE) begin
      wdata_ready_s = 1'b1;
    end else begin
      wdata_ready_s = 1'b0;
    end
    wr_hs_s = i_wdata_valid & wdata_ready_s;

    last_beat_s   = (beat_cnt_r == '0);

    // Beats already buffered plus reads whose data has not yet been captured.
    read_in_use_s = {1'b0, fifo_cnt_r} + {2'b00, sram_oen_r} + {2'b00, cap_pend_r};

    if ((state_r == ST_READ) && (read_in_use_s < 3'd2)) begin
      rd_issue_s = 1'b1;
    end else begin
      rd_issue_s = 1'b0;
    end

    beat_issue_s  = wr_hs_s | rd_issue_s;

    rdata_valid_s = (fifo_cnt_r != 2'd0);
    fifo_push_s   = cap_pend_r;
    fifo_pop_s    = rdata_valid_s & i_rdata_ready;

    // The final read beat leaves when only one beat remains anywhere.
    if ((state_r == ST_DRAIN) && fifo_pop_s && (fifo_cnt_r == 2'd1) &&
        !sram_oen_r && !cap_pend_r) begin
      drain_last_s = 1'b1;
    end else begin
      drain_last_s = 1'b0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_hs_s) begin
          if (i_cmd_wr) begin
            state_nxt_s = ST_WRITE;
          end else begin
            state_nxt_s = ST_READ;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (wr_hs_s && last_beat_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_WRITE;
        end
      end
      ST_READ: begin
        if (rd_issue_s && last_beat_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (drain_last_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Burst address and remaining-beat counter; the address wraps naturally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cur_addr_r <= '0;
      beat_cnt_r <= '0;
    end else if (cmd_hs_s) begin
      cur_addr_r <= i_cmd_addr;
      beat_cnt_r <= i_cmd_len;
    end else if (beat_issue_s) begin
      cur_addr_r <= cur_addr_r + ADDR_ONE;
      beat_cnt_r <= beat_cnt_r - ADDR_ONE;
    end else begin
      cur_addr_r <= cur_addr_r;
      beat_cnt_r <= beat_cnt_r;
    end
  end

  // SRAM port registers; address and data hold when no access is issued.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sram_wen_r  <= 1'b0;
      sram_oen_r  <= 1'b0;
      sram_addr_r <= '0;
      sram_data_r <= '0;
    end else begin
      sram_wen_r <= wr_hs_s;
      sram_oen_r <= rd_issue_s;
      if (beat_issue_s) begin
        sram_addr_r <= cur_addr_r;
      end else begin
        sram_addr_r <= sram_addr_r;
      end
      if (wr_hs_s) begin
        sram_data_r <= i_wdata;
      end else begin
        sram_data_r <= sram_data_r;
      end
    end
  end

  // Read-data capture marker, one cycle behind oen; reset drops in-flight data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cap_pend_r <= 1'b0;
    end else begin
      cap_pend_r <= sram_oen_r;
    end
  end

  // Two-entry read buffer; a capture and a pop in one cycle both take effect.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      fifo_mem_r[0] <= '0;
      fifo_mem_r[1] <= '0;
      fifo_wr_ptr_r <= 1'b0;
      fifo_rd_ptr_r <= 1'b0;
      fifo_cnt_r    <= 2'd0;
    end else begin
      if (fifo_push_s) begin
        fifo_mem_r[fifo_wr_ptr_r] <= i_sram_data;
        fifo_wr_ptr_r             <= ~fifo_wr_ptr_r;
      end else begin
        fifo_wr_ptr_r <= fifo_wr_ptr_r;
      end
      if (fifo_pop_s) begin
        fifo_rd_ptr_r <= ~fifo_rd_ptr_r;
      end else begin
        fifo_rd_ptr_r <= fifo_rd_ptr_r;
      end
      case ({fifo_push_s, fifo_pop_s})
        2'b10:   fifo_cnt_r <= fifo_cnt_r + 2'd1;
        2'b01:   fifo_cnt_r <= fifo_cnt_r - 2'd1;
        default: fifo_cnt_r <= fifo_cnt_r;
      endcase
    end
  end

  // Write completion pulse lines up with the final beat's wen.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      done_r <= 1'b0;
    end else begin
      done_r <= wr_hs_s & last_beat_s;
    end
  end

  assign o_cmd_ready   = cmd_ready_s;
  assign o_wdata_ready = wdata_ready_s;
  assign o_rdata_valid = rdata_valid_s;
  assign o_rdata       = fifo_mem_r[fifo_rd_ptr_r];
  assign o_sram_addr   = sram_addr_r;
  assign o_sram_data   = sram_data_r;
  assign o_sram_wen    = sram_wen_r;
  assign o_sram_oen    = sram_oen_r;
  assign o_busy        = (state_r != ST_IDLE);
  // Read completion must coincide with acceptance of the last beat.
  assign o_done        = done_r | drain_last_s;

  sram_burst_ctrl_chk u_chk (
    .clk         (i_clk),
    .rst         (i_rst),
    .sram_wen    (sram_wen_r),
    .sram_oen    (sram_oen_r),
    .read_in_use (read_in_use_s)
  );

endmodule

// File: tb/tb_sram_burst_ctrl.sv
module tb_sram_burst_ctrl;

  localparam int BW_DATA = 256;
  localparam int BW_ADDR = 10;

  logic               clk = 1'b0;
  logic               rst;
  logic               i_cmd_valid;
  logic               o_cmd_ready;
  logic               i_cmd_wr;
  logic [BW_ADDR-1:0] i_cmd_addr;
  logic [BW_ADDR-1:0] i_cmd_len;
  logic               i_wdata_valid;
  logic               o_wdata_ready;
  logic [BW_DATA-1:0] i_wdata;
  logic               o_rdata_valid;
  logic               i_rdata_ready;
  logic [BW_DATA-1:0] o_rdata;
  logic [BW_ADDR-1:0] o_sram_addr;
  logic [BW_DATA-1:0] o_sram_data;
  logic               o_sram_wen;
  logic               o_sram_oen;
  logic [BW_DATA-1:0] i_sram_data;
  logic               o_busy;
  logic               o_done;

  always #5 clk = ~clk;

  sram_burst_ctrl #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_wr(i_cmd_wr),
    .i_cmd_addr(i_cmd_addr), .i_cmd_len(i_cmd_len),
    .i_wdata_valid(i_wdata_valid), .o_wdata_ready(o_wdata_ready), .i_wdata(i_wdata),
    .o_rdata_valid(o_rdata_valid), .i_rdata_ready(i_rdata_ready), .o_rdata(o_rdata),
    .o_sram_addr(o_sram_addr), .o_sram_data(o_sram_data),
    .o_sram_wen(o_sram_wen), .o_sram_oen(o_sram_oen), .i_sram_data(i_sram_data),
    .o_busy(o_busy), .o_done(o_done)
  );

  // ---------------- SRAM device: one-cycle read latency ----------------
  logic               sram_init;
  logic [BW_DATA-1:0] sram_mem [1024];
  logic [BW_DATA-1:0] sram_q;

  function automatic logic [BW_DATA-1:0] init_word(input int i);
    logic [BW_DATA-1:0] w;
    w = 256'h1000;
    return w + BW_DATA'(i);
  endfunction

  always @(posedge clk) begin
    if (sram_init) begin
      for (int i = 0; i < 1024; i++) sram_mem[i] <= init_word(i);
    end else begin
      if (o_sram_wen) sram_mem[o_sram_addr] <= o_sram_data;
      if (o_sram_oen) sram_q <= sram_mem[o_sram_addr];
    end
  end
  assign i_sram_data = sram_q;

  // ---------------- bookkeeping ----------------
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [BW_DATA-1:0] act,
                     input logic [BW_DATA-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_mode: 0 idle, 1 write burst, 2 read burst (until its last beat is taken)
  int                 m_mode;
  logic [BW_ADDR-1:0] m_addr;
  int                 m_left;
  logic [BW_ADDR-1:0] m_iss_addr;
  int                 m_iss_left;
  int                 m_acc_left;
  int                 outstanding;
  int                 max_out;
  logic               pend_wen;
  logic               pend_done;
  logic [BW_ADDR-1:0] pend_addr;
  logic [BW_DATA-1:0] pend_data;
  logic [BW_ADDR-1:0] m_last_addr;
  logic [BW_DATA-1:0] m_last_data;
  logic [BW_DATA-1:0] exp_mem [1024];
  logic [BW_DATA-1:0] exp_q [$];

  int                 cyc;
  int                 done_cnt;
  int                 done_cyc;
  int                 oen_cnt;
  logic [BW_ADDR-1:0] wen_log_addr [$];
  logic [BW_DATA-1:0] wen_log_data [$];
  int                 wen_log_cyc [$];
  logic [BW_DATA-1:0] rd_log [$];

  initial begin
    int                 cur_mode;
    logic               exp_done_v;
    logic               rd_finish;
    logic [BW_ADDR-1:0] a;
    m_mode = 0; outstanding = 0; max_out = 0; pend_wen = 1'b0; pend_done = 1'b0;
    m_last_addr = '0; m_last_data = '0; cyc = 0; done_cnt = 0; done_cyc = 0; oen_cnt = 0;
    m_iss_left = 0; m_acc_left = 0; m_left = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (sram_init) begin
        for (int i = 0; i < 1024; i++) exp_mem[i] = init_word(i);
      end
      if (rst) begin
        chk("rst_cmd_ready", o_cmd_ready, 0);
        chk("rst_wdata_ready", o_wdata_ready, 0);
        chk("rst_rdata_valid", o_rdata_valid, 0);
        chk("rst_wen", o_sram_wen, 0);
        chk("rst_oen", o_sram_oen, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_sram_addr", o_sram_addr, 0);
        chk("rst_sram_data", o_sram_data, 0);
        chk("rst_rdata", o_rdata, 0);
        m_mode = 0; outstanding = 0; pend_wen = 1'b0; pend_done = 1'b0;
        m_last_addr = '0; m_last_data = '0; exp_q.delete();
      end else begin
        cur_mode   = m_mode;
        exp_done_v = pend_done;
        rd_finish  = 1'b0;
        chk("cmd_ready", o_cmd_ready, cur_mode == 0);
        chk("wdata_ready", o_wdata_ready, cur_mode == 1);
        chk("busy", o_busy, cur_mode != 0);
        chk("sram_wen", o_sram_wen, pend_wen);
        chk("wen_oen_exclusive", o_sram_wen && o_sram_oen, 0);
        if (pend_wen) begin
          m_last_addr = pend_addr;
          m_last_data = pend_data;
        end
        if (o_sram_wen) begin
          wen_log_addr.push_back(o_sram_addr);
          wen_log_data.push_back(o_sram_data);
          wen_log_cyc.push_back(cyc);
        end
        if (o_sram_oen) begin
          oen_cnt++;
          chk("oen_in_read_burst", (cur_mode == 2) && (m_iss_left > 0), 1);
          m_last_addr = m_iss_addr;
          m_iss_addr  = m_iss_addr + 10'd1;
          m_iss_left--;
          outstanding++;
          if (outstanding > max_out) max_out = outstanding;
          chk("read_outstanding_le2", outstanding <= 2, 1);
        end
        chk("sram_addr", o_sram_addr, m_last_addr);
        chk("sram_data", o_sram_data, m_last_data);
        if (cur_mode != 2) chk("rdata_valid_outside_read", o_rdata_valid, 0);
        if (o_rdata_valid && i_rdata_ready) begin
          rd_log.push_back(o_rdata);
          chk("rbeat_expected", (cur_mode == 2) && (exp_q.size() > 0), 1);
          if ((cur_mode == 2) && (exp_q.size() > 0)) begin
            chk("rdata", o_rdata, exp_q[0]);
            exp_q.pop_front();
            outstanding--;
            m_acc_left--;
            if (m_acc_left == 0) begin
              exp_done_v = 1'b1;
              rd_finish  = 1'b1;
            end
          end
        end
        chk("done", o_done, exp_done_v);
        if (o_done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        // advance the model across the coming clock edge
        pend_wen  = 1'b0;
        pend_done = 1'b0;
        if (rd_finish) m_mode = 0;
        if ((cur_mode == 0) && i_cmd_valid) begin
          m_addr = i_cmd_addr;
          m_left = int'(i_cmd_len);
          if (i_cmd_wr) begin
            m_mode = 1;
          end else begin
            m_mode     = 2;
            m_iss_addr = i_cmd_addr;
            m_iss_left = int'(i_cmd_len) + 1;
            m_acc_left = int'(i_cmd_len) + 1;
            for (int i = 0; i <= int'(i_cmd_len); i++) begin
              a = i_cmd_addr + BW_ADDR'(i);
              exp_q.push_back(exp_mem[a]);
            end
          end
        end
        if ((cur_mode == 1) && i_wdata_valid) begin
          pend_wen  = 1'b1;
          pend_addr = m_addr;
          pend_data = i_wdata;
          pend_done = (m_left == 0);
          exp_mem[m_addr] = i_wdata;
          m_addr = m_addr + 10'd1;
          if (m_left == 0) m_mode = 0;
          else m_left--;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    int n;
    n = 0;
    while ((m_mode != 0) && (n < max_cyc)) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk(name, m_mode == 0, 1);
  endtask

  task automatic send_cmd(input logic wr, input logic [BW_ADDR-1:0] addr,
                          input logic [BW_ADDR-1:0] len);
    i_cmd_valid = 1'b1;
    i_cmd_wr    = wr;
    i_cmd_addr  = addr;
    i_cmd_len   = len;
    @(posedge clk);
    #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic write_beats(input int len, input logic [BW_DATA-1:0] base,
                             input logic toggle);
    int   k;
    int   c;
    logic hs;
    k = 0;
    c = 0;
    while ((k <= len) && (c < 100)) begin
      i_wdata_valid = toggle ? ((c % 2) == 0) : 1'b1;
      i_wdata       = base + BW_DATA'(k);
      @(negedge clk);
      hs = i_wdata_valid && o_wdata_ready;
      @(posedge clk);
      #1;
      if (hs) k++;
      c++;
    end
    i_wdata_valid = 1'b0;
    chk("write_beats_sent", k, len + 1);
  endtask

  task automatic clear_logs();
    wen_log_addr.delete();
    wen_log_data.delete();
    wen_log_cyc.delete();
    rd_log.delete();
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int d0;
    int o0;
    rst = 1'b1; sram_init = 1'b1;
    i_cmd_valid = 1'b0; i_cmd_wr = 1'b0; i_cmd_addr = '0; i_cmd_len = '0;
    i_wdata_valid = 1'b0; i_wdata = '0; i_rdata_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 sram_init = 1'b0;
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk("cmd_ready_after_reset", o_cmd_ready, 1);
    idle_cycles(2);

    // write addr 0, len 3, data 0..3, valid always high
    clear_logs(); d0 = done_cnt;
    send_cmd(1'b1, 10'd0, 10'd3);
    write_beats(3, 256'h0, 1'b0);
    wait_idle("wr0_idle", 50); idle_cycles(3);
    chk("wr0_wen_count", wen_log_addr.size(), 4);
    for (int k = 0; (k < 4) && (k < wen_log_addr.size()); k++) begin
      chk("wr0_addr", wen_log_addr[k], k);
      chk("wr0_data", wen_log_data[k], k);
      chk("wr0_consecutive", wen_log_cyc[k] - wen_log_cyc[0], k);
    end
    chk("wr0_done_count", done_cnt - d0, 1);
    if (wen_log_cyc.size() == 4) chk("wr0_done_on_4th_wen", done_cyc, wen_log_cyc[3]);

    // read addr 0, len 3, ready always high
    clear_logs(); d0 = done_cnt; i_rdata_ready = 1'b1;
    send_cmd(1'b0, 10'd0, 10'd3);
    wait_idle("rd0_idle", 60); idle_cycles(3);
    chk("rd0_beats", rd_log.size(), 4);
    for (int k = 0; (k < 4) && (k < rd_log.size()); k++) chk("rd0_data", rd_log[k], k);
    chk("rd0_no_wen", wen_log_addr.size(), 0);
    chk("rd0_done_count", done_cnt - d0, 1);

    // read addr 100, len 7, consumer stalls 5 cycles
    clear_logs(); d0 = done_cnt; o0 = oen_cnt; max_out = 0; i_rdata_ready = 1'b0;
    send_cmd(1'b0, 10'd100, 10'd7);
    repeat (5) @(posedge clk);
    #1;
    chk("rd1_oen_during_stall", oen_cnt - o0, 2);
    chk("rd1_no_beats_during_stall", rd_log.size(), 0);
    i_rdata_ready = 1'b1;
    wait_idle("rd1_idle", 100); idle_cycles(3);
    chk("rd1_beats", rd_log.size(), 8);
    for (int k = 0; (k < 8) && (k < rd_log.size()); k++)
      chk("rd1_data", rd_log[k], 256'h1064 + BW_DATA'(k));
    chk("rd1_max_buffered", max_out <= 2, 1);
    chk("rd1_oen_count", oen_cnt - o0, 8);
    chk("rd1_done_count", done_cnt - d0, 1);

    // write addr 1022, len 3: address wrap
    clear_logs(); d0 = done_cnt;
    send_cmd(1'b1, 10'd1022, 10'd3);
    write_beats(3, 256'hAA00, 1'b0);
    wait_idle("wr1_idle", 50); idle_cycles(3);
    chk("wr1_wen_count", wen_log_addr.size(), 4);
    if (wen_log_addr.size() == 4) begin
      chk("wr1_addr0", wen_log_addr[0], 10'd1022);
      chk("wr1_addr1", wen_log_addr[1], 10'd1023);
      chk("wr1_addr2", wen_log_addr[2], 10'd0);
      chk("wr1_addr3", wen_log_addr[3], 10'd1);
      chk("wr1_data3", wen_log_data[3], 256'hAA03);
    end
    chk("wr1_done_count", done_cnt - d0, 1);

    // write addr 10, len 3, valid toggling every other cycle
    clear_logs(); d0 = done_cnt;
    send_cmd(1'b1, 10'd10, 10'd3);
    write_beats(3, 256'hB0, 1'b1);
    wait_idle("wr2_idle", 50); idle_cycles(3);
    chk("wr2_wen_count", wen_log_addr.size(), 4);
    for (int k = 1; (k < 4) && (k < wen_log_cyc.size()); k++) begin
      chk("wr2_wen_spacing", wen_log_cyc[k] - wen_log_cyc[k-1], 2);
      chk("wr2_addr", wen_log_addr[k], 10'd10 + BW_ADDR'(k));
    end
    chk("wr2_done_count", done_cnt - d0, 1);

    // reset during the 2nd beat of a len-7 read
    clear_logs(); d0 = done_cnt; i_rdata_ready = 1'b1;
    send_cmd(1'b0, 10'd0, 10'd7);
    for (int i = 0; (i < 50) && (rd_log.size() < 1); i++) begin
      @(posedge clk);
      #2;
    end
    chk("rst_mid_first_beat_seen", rd_log.size() >= 1, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_rdata_valid", o_rdata_valid, 0);
    chk("rst_mid_oen", o_sram_oen, 0);
    chk("rst_mid_done", o_done, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    idle_cycles(2);
    chk("rst_mid_no_done", done_cnt - d0, 0);

    // len-0 write to addr 5, then read it back
    clear_logs(); d0 = done_cnt;
    send_cmd(1'b1, 10'd5, 10'd0);
    write_beats(0, 256'h55, 1'b0);
    wait_idle("wr3_idle", 20); idle_cycles(3);
    chk("wr3_wen_count", wen_log_addr.size(), 1);
    if (wen_log_addr.size() == 1) begin
      chk("wr3_addr", wen_log_addr[0], 10'd5);
      chk("wr3_data", wen_log_data[0], 256'h55);
    end
    chk("wr3_done_count", done_cnt - d0, 1);
    clear_logs(); d0 = done_cnt;
    send_cmd(1'b0, 10'd5, 10'd0);
    wait_idle("rd3_idle", 20); idle_cycles(3);
    chk("rd3_beats", rd_log.size(), 1);
    if (rd_log.size() == 1) chk("rd3_data", rd_log[0], 256'h55);
    chk("rd3_done_count", done_cnt - d0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
